// File: rtl/pid_compensator_if.sv
// Sample/error/clear inputs and duty/status outputs for the PID compensator.
// The master side drives smp/en/clr; the slave side returns duty and flags.
// The bus carries no flow control: status flags (busy, ovr) report rejected samples.
interface pid_if #(
    parameter int DW = 10
);
    logic          smp;
    logic [3:0]    en;
    logic          clr;
    logic [DW-1:0] duty;
    logic          duty_vld;
    logic          sat_hi;
    logic          sat_lo;
    logic          busy;
    logic          ovr;

    modport master (
        output smp, en, clr,
        input  duty, duty_vld, sat_hi, sat_lo, busy, ovr
    );

    modport slave (
        input  smp, en, clr,
        output duty, duty_vld, sat_hi, sat_lo, busy, ovr
    );
endinterface

// File: rtl/pid_compensator.sv
// Incremental PID compensator: error history -> clamped fixed-point integrator -> duty.
// Latency: 2 clocks from an accepted smp to the duty/duty_vld update.
// No backpressure: a smp arriving while busy is dropped and latches the sticky ovr flag.
module pid_compensator #(
    parameter int              DW        = 10,
    parameter int              FRAC      = 4,
    parameter logic signed [7:0] KA      = 8'sd24,
    parameter logic signed [7:0] KB      = -8'sd20,
    parameter logic signed [7:0] KC      = 8'sd0,
    parameter int              DUTY_INIT = 512,
    parameter int              DUTY_MIN  = 32,
    parameter int              DUTY_MAX  = 992
) (
    input logic  clk,
    input logic  rst,
    pid_if.slave bus
);
    localparam int ACCW = DW + FRAC + 2;
    localparam int PW   = 14;

    // Window limits in accumulator (fixed-point) units.
    localparam logic signed [ACCW-1:0] ACC_INIT = ACCW'(DUTY_INIT << FRAC);
    localparam logic signed [ACCW-1:0] ACC_MIN  = ACCW'(DUTY_MIN << FRAC);
    localparam logic signed [ACCW-1:0] ACC_MAX  = ACCW'(DUTY_MAX << FRAC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        UPD  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic signed [3:0]      e0;
    logic signed [3:0]      e1;
    logic signed [3:0]      e2;
    logic signed [PW-1:0]   psum;
    logic signed [PW-1:0]   pa;
    logic signed [PW-1:0]   pb;
    logic signed [PW-1:0]   pc;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] nxt;
    logic signed [ACCW-1:0] acc_new;
    logic                   hi_new;
    logic                   lo_new;

    function automatic logic signed [PW-1:0] sx8(input logic signed [7:0] v);
        return $signed({{(PW-8){v[7]}}, v});
    endfunction

    function automatic logic signed [PW-1:0] sx4(input logic signed [3:0] v);
        return $signed({{(PW-4){v[3]}}, v});
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one pass IDLE -> CALC -> UPD -> IDLE per accepted sample; clr forces IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.smp ? CALC : IDLE;
            CALC:    state_nxt = UPD;
            UPD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.clr) begin
            state_nxt = IDLE;
        end
    end

    assign bus.busy = (state != IDLE);

    // Coefficient products; 14 bits hold the worst case of three 8x4 products.
    always_comb begin
        pa = sx8(KA) * sx4(e0);
        pb = sx8(KB) * sx4(e1);
        pc = sx8(KC) * sx4(e2);
    end

    // Integrator step with anti-windup: the accumulator itself is pinned to the window.
    always_comb begin
        nxt     = acc + $signed({{(ACCW-PW){psum[PW-1]}}, psum});
        acc_new = nxt;
        hi_new  = 1'b0;
        lo_new  = 1'b0;
        if (nxt > ACC_MAX) begin
            acc_new = ACC_MAX;
            hi_new  = 1'b1;
        end else if (nxt < ACC_MIN) begin
            acc_new = ACC_MIN;
            lo_new  = 1'b1;
        end
    end

    // Datapath: history shift on accept, psum in CALC, accumulator/duty commit in UPD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0           <= '0;
            e1           <= '0;
            e2           <= '0;
            psum         <= '0;
            acc          <= ACC_INIT;
            bus.duty     <= DW'(DUTY_INIT);
            bus.duty_vld <= 1'b0;
            bus.sat_hi   <= 1'b0;
            bus.sat_lo   <= 1'b0;
            bus.ovr      <= 1'b0;
        end else if (bus.clr) begin
            e0           <= '0;
            e1           <= '0;
            e2           <= '0;
            acc          <= ACC_INIT;
            bus.duty     <= DW'(DUTY_INIT);
            bus.duty_vld <= 1'b0;
            bus.sat_hi   <= 1'b0;
            bus.sat_lo   <= 1'b0;
            bus.ovr      <= 1'b0;
        end else begin
            bus.duty_vld <= 1'b0;
            if (bus.smp && state != IDLE) begin
                bus.ovr <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.smp) begin
                        e2 <= e1;
                        e1 <= e0;
                        e0 <= $signed(bus.en);
                    end
                end
                CALC: begin
                    psum <= pa + pb + pc;
                end
                UPD: begin
                    acc          <= acc_new;
                    bus.duty     <= acc_new[FRAC +: DW];
                    bus.sat_hi   <= hi_new;
                    bus.sat_lo   <= lo_new;
                    bus.duty_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pid_compensator.sv
// Self-checking bench: directed literal scenarios plus randomized smp/en/clr traffic.
// A sample-level reference model predicts duty and flags after every clock edge.
// Outputs are compared on the falling edge; inputs change 1 time unit after the rising edge.
module tb_pid_compensator;
    localparam int DW        = 10;
    localparam int FRAC      = 4;
    localparam int KA        = 24;
    localparam int KB        = -20;
    localparam int KC        = 0;
    localparam int DUTY_INIT = 512;
    localparam int DUTY_MIN  = 32;
    localparam int DUTY_MAX  = 992;

    logic clk;
    logic rst;

    pid_if #(.DW(DW)) bus ();

    pid_compensator #(
        .DW(DW), .FRAC(FRAC), .KA(8'sd24), .KB(-8'sd20), .KC(8'sd0),
        .DUTY_INIT(DUTY_INIT), .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int vld_count = 0;
    bit chk_en   = 0;

    // Reference model state (sample-level view).
    int m_acc = DUTY_INIT << FRAC;
    int m_duty = DUTY_INIT;
    int h0 = 0, h1 = 0, h2 = 0;
    int m_wait = 0;       // clocks remaining until the pending update lands (0 = none)
    bit m_vld = 0, m_hi = 0, m_lo = 0, m_ovr = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_acc  = DUTY_INIT << FRAC;
        m_duty = DUTY_INIT;
        h0 = 0; h1 = 0; h2 = 0;
        m_wait = 0;
        m_vld = 0; m_hi = 0; m_lo = 0; m_ovr = 0;
    endtask

    // Reference model: each accepted sample updates duty two clocks later.
    initial begin
        int nxt;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_clear();
            end else if (bus.clr) begin
                model_clear();
            end else begin
                m_vld = 0;
                if (bus.smp && m_wait != 0) m_ovr = 1;
                if (m_wait == 2) begin
                    m_wait = 1;
                end else if (m_wait == 1) begin
                    nxt = m_acc + KA * h0 + KB * h1 + KC * h2;
                    m_hi = 0; m_lo = 0;
                    if (nxt > (DUTY_MAX << FRAC)) begin
                        m_acc = DUTY_MAX << FRAC; m_hi = 1;
                    end else if (nxt < (DUTY_MIN << FRAC)) begin
                        m_acc = DUTY_MIN << FRAC; m_lo = 1;
                    end else begin
                        m_acc = nxt;
                    end
                    m_duty = m_acc / (1 << FRAC);
                    m_vld  = 1;
                    m_wait = 0;
                end else if (bus.smp) begin
                    h2 = h1;
                    h1 = h0;
                    h0 = int'($signed(bus.en));
                    m_wait = 2;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("duty", int'(bus.duty), m_duty);
                chk("duty_vld", int'(bus.duty_vld), int'(m_vld));
                chk("sat_hi", int'(bus.sat_hi), int'(m_hi));
                chk("sat_lo", int'(bus.sat_lo), int'(m_lo));
                chk("busy", int'(bus.busy), int'(m_wait != 0));
                chk("ovr", int'(bus.ovr), int'(m_ovr));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.duty_vld === 1'b1) vld_count++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic pulse(input logic [3:0] e);
        @(posedge clk); #1;
        bus.smp = 1'b1;
        bus.en  = e;
        @(posedge clk); #1;
        bus.smp = 1'b0;
    endtask

    task automatic do_clr();
        @(posedge clk); #1;
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
    endtask

    task automatic wait_vld(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.duty_vld === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk({name, "_vld_seen"}, int'(seen), 1);
    endtask

    initial begin
        int v0;
        int iters;
        rst = 1'b0;
        bus.smp = 1'b0;
        bus.en  = 4'd0;
        bus.clr = 1'b0;
        #2 rst = 1'b1;
        #20 rst = 1'b0;
        @(negedge clk);
        chk_en = 1;

        // Reset state.
        chk("rst_duty", int'(bus.duty), 512);
        chk("rst_vld", int'(bus.duty_vld), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ovr", int'(bus.ovr), 0);
        chk("rst_sat", int'({bus.sat_hi, bus.sat_lo}), 0);

        // Single steps with default coefficients.
        pulse(4'b0100);
        wait_vld("step1");
        chk("step1_duty", int'(bus.duty), 518);
        pulse(4'b0100);
        wait_vld("step2");
        chk("step2_duty", int'(bus.duty), 519);

        // Drive down into the low clamp.
        iters = 0;
        do begin
            pulse(4'b1100);
            wait_vld("low");
            iters++;
        end while (!bus.sat_lo && iters < 1000);
        chk("low_duty", int'(bus.duty), 32);
        chk("low_sat_lo", int'(bus.sat_lo), 1);
        pulse(4'b1100);
        wait_vld("low_hold");
        chk("low_hold_duty", int'(bus.duty), 32);
        pulse(4'b0100);
        wait_vld("low_rel");
        chk("low_rel_duty", int'(bus.duty), 43);
        chk("low_rel_sat_lo", int'(bus.sat_lo), 0);

        // Drive up into the high clamp.
        do_clr();
        iters = 0;
        do begin
            pulse(4'b0100);
            wait_vld("high");
            iters++;
        end while (!bus.sat_hi && iters < 1500);
        chk("high_duty", int'(bus.duty), 992);
        chk("high_sat_hi", int'(bus.sat_hi), 1);
        pulse(4'b0100);
        wait_vld("high_hold");
        chk("high_hold_duty", int'(bus.duty), 992);

        // Overrun: smp on two consecutive edges.
        do_clr();
        v0 = vld_count;
        @(posedge clk); #1;
        bus.smp = 1'b1; bus.en = 4'b0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.smp = 1'b0;
        repeat (6) @(negedge clk);
        chk("ovr_vld_count", vld_count - v0, 1);
        chk("ovr_duty", int'(bus.duty), 518);
        chk("ovr_flag", int'(bus.ovr), 1);
        do_clr();
        @(negedge clk);
        chk("ovr_clr_flag", int'(bus.ovr), 0);
        chk("ovr_clr_duty", int'(bus.duty), 512);

        // Reset while the update is in flight.
        pulse(4'b0100);
        v0 = vld_count;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstmid_vld_count", vld_count - v0, 0);
        chk("rstmid_duty", int'(bus.duty), 512);
        pulse(4'b0100);
        wait_vld("rstmid_next");
        chk("rstmid_next_duty", int'(bus.duty), 518);

        // Randomized traffic, including overruns, clr collisions and the -8 code.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.smp = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 99) < 3)
                bus.en = 4'b1000;
            else
                bus.en = 4'($urandom_range(0, 8) - 4);
            bus.clr = ($urandom_range(0, 99) < 2);
        end
        @(posedge clk); #1;
        bus.smp = 1'b0;
        bus.clr = 1'b0;
        repeat (5) @(negedge clk);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
